// File: rtl/regfile_2r1w_sb.sv
// Two-read, one-write register file with write-first bypass and a busy
// scoreboard for read-after-write hazard detection.
module regfile_2r1w_sb #(
    parameter int N         = 16,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int INIT_ONES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w,
    input  logic [AW-1:0]    wsel,
    input  logic [N-1:0]     wdata,
    input  logic [AW-1:0]    ra_sel,
    input  logic [AW-1:0]    rb_sel,
    output logic [N-1:0]     ra_data,
    output logic [N-1:0]     rb_data,
    output logic             busy_a,
    output logic             busy_b,
    input  logic             lock,
    input  logic [AW-1:0]    lock_sel,
    output logic             lock_err,
    output logic [DEPTH-1:0] busy_vec
);

    logic [N-1:0]     regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic [N-1:0]     ra_next;
    logic [N-1:0]     rb_next;
    logic             ba_next;
    logic             bb_next;
    logic             lock_hit;

    // Selects outside 0..DEPTH-1 never match a loop index, so they read as
    // zero/not-busy and their writes and locks fall away naturally.
    always_comb begin
        busy_next = busy;
        ra_next   = '0;
        rb_next   = '0;
        ba_next   = 1'b0;
        bb_next   = 1'b0;
        lock_hit  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (lock && lock_sel == AW'(i)) begin
                busy_next[i] = 1'b1;
            end else if (w && wsel == AW'(i)) begin
                busy_next[i] = 1'b0;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (lock_sel == AW'(i)) begin
                lock_hit = busy[i];
            end
            if (ra_sel == AW'(i)) begin
                ra_next = (w && wsel == ra_sel) ? wdata : regs[i];
                ba_next = busy_next[i];
            end
            if (rb_sel == AW'(i)) begin
                rb_next = (w && wsel == rb_sel) ? wdata : regs[i];
                bb_next = busy_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (i < INIT_ONES) ? N'(1) : '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w && wsel == AW'(i)) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // Busy flags are registered from the post-update scoreboard so they
    // line up with the data captured on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= '0;
            ra_data  <= '0;
            rb_data  <= '0;
            busy_a   <= 1'b0;
            busy_b   <= 1'b0;
            lock_err <= 1'b0;
        end else begin
            busy     <= busy_next;
            ra_data  <= ra_next;
            rb_data  <= rb_next;
            busy_a   <= ba_next;
            busy_b   <= bb_next;
            lock_err <= lock && lock_hit;
        end
    end

    assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Directed, table-driven bench for regfile_2r1w_sb: a default-size instance
// plus a DEPTH=12 instance sharing the same inputs.
module tb_regfile_2r1w_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w = 1'b0;
    logic [3:0]  wsel = '0;
    logic [15:0] wdata = '0;
    logic [3:0]  ra_sel = '0;
    logic [3:0]  rb_sel = '0;
    logic        lock = 1'b0;
    logic [3:0]  lock_sel = '0;

    logic [15:0] ra_data, rb_data;
    logic        busy_a, busy_b, lock_err;
    logic [15:0] busy_vec;

    logic [15:0] ra_data12, rb_data12;
    logic        busy_a12, busy_b12, lock_err12;
    logic [11:0] busy_vec12;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    regfile_2r1w_sb dut (
        .clk(clk), .rst(rst), .w(w), .wsel(wsel), .wdata(wdata),
        .ra_sel(ra_sel), .rb_sel(rb_sel), .ra_data(ra_data), .rb_data(rb_data),
        .busy_a(busy_a), .busy_b(busy_b), .lock(lock), .lock_sel(lock_sel),
        .lock_err(lock_err), .busy_vec(busy_vec)
    );

    regfile_2r1w_sb #(.N(16), .DEPTH(12), .AW(4), .INIT_ONES(3)) dut12 (
        .clk(clk), .rst(rst), .w(w), .wsel(wsel), .wdata(wdata),
        .ra_sel(ra_sel), .rb_sel(rb_sel), .ra_data(ra_data12), .rb_data(rb_data12),
        .busy_a(busy_a12), .busy_b(busy_b12), .lock(lock), .lock_sel(lock_sel),
        .lock_err(lock_err12), .busy_vec(busy_vec12)
    );

    typedef struct {
        logic        w;
        logic [3:0]  wsel;
        logic [15:0] wdata;
        logic [3:0]  ra_sel;
        logic [3:0]  rb_sel;
        logic        lock;
        logic [3:0]  lock_sel;
        logic [15:0] ra_exp;
        logic [15:0] rb_exp;
        logic        ba_exp;
        logic        bb_exp;
        logic        err_exp;
        logic [15:0] vec_exp;
    } vec_t;

    vec_t vecs [13];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then wait until just
    // after the next rising edge so outputs can be sampled.
    task automatic apply_stimulus(input logic w_i, input logic [3:0] wsel_i,
                                  input logic [15:0] wdata_i, input logic [3:0] ra_i,
                                  input logic [3:0] rb_i, input logic lock_i,
                                  input logic [3:0] lsel_i);
        @(negedge clk);
        w        = w_i;
        wsel     = wsel_i;
        wdata    = wdata_i;
        ra_sel   = ra_i;
        rb_sel   = rb_i;
        lock     = lock_i;
        lock_sel = lsel_i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 4'd0, 16'h0000, 4'd0, 4'd3,  1'b0, 4'd0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 4'd0, 16'h0000, 4'd2, 4'd15, 1'b0, 4'd0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[2]  = '{1'b1, 4'd5, 16'hBEEF, 4'd1, 4'd0,  1'b0, 4'd0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[3]  = '{1'b0, 4'd0, 16'h0000, 4'd5, 4'd4,  1'b0, 4'd0, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[4]  = '{1'b1, 4'd7, 16'h1234, 4'd7, 4'd7,  1'b0, 4'd0, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[5]  = '{1'b0, 4'd0, 16'h0000, 4'd4, 4'd5,  1'b1, 4'd4, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0010};
        vecs[6]  = '{1'b0, 4'd0, 16'h0000, 4'd4, 4'd5,  1'b1, 4'd4, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 1'b1, 16'h0010};
        vecs[7]  = '{1'b0, 4'd0, 16'h0000, 4'd4, 4'd5,  1'b0, 4'd0, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0010};
        vecs[8]  = '{1'b1, 4'd4, 16'h00AA, 4'd4, 4'd7,  1'b0, 4'd0, 16'h00AA, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[9]  = '{1'b1, 4'd9, 16'h5A5A, 4'd9, 4'd4,  1'b1, 4'd9, 16'h5A5A, 16'h00AA, 1'b1, 1'b0, 1'b0, 16'h0200};
        vecs[10] = '{1'b1, 4'd3, 16'h0F0F, 4'd3, 4'd9,  1'b0, 4'd0, 16'h0F0F, 16'h5A5A, 1'b0, 1'b1, 1'b0, 16'h0200};
        vecs[11] = '{1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0,  1'b0, 4'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0200};
        vecs[12] = '{1'b0, 4'd0, 16'h0000, 4'd9, 4'd0,  1'b1, 4'd9, 16'h5A5A, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'h0200};

        // Asynchronous reset without any clock edge
        #2 rst = 1'b0;
        #1;
        check_output("rst.ra_data", 32'(ra_data), 32'h0);
        check_output("rst.rb_data", 32'(rb_data), 32'h0);
        check_output("rst.busy_a", 32'(busy_a), 32'h0);
        check_output("rst.busy_b", 32'(busy_b), 32'h0);
        check_output("rst.lock_err", 32'(lock_err), 32'h0);
        check_output("rst.busy_vec", 32'(busy_vec), 32'h0);
        check_output("rst.busy_vec12", 32'(busy_vec12), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i].w, vecs[i].wsel, vecs[i].wdata, vecs[i].ra_sel,
                           vecs[i].rb_sel, vecs[i].lock, vecs[i].lock_sel);
            check_output($sformatf("v%0d.ra_data", i), 32'(ra_data), 32'(vecs[i].ra_exp));
            check_output($sformatf("v%0d.rb_data", i), 32'(rb_data), 32'(vecs[i].rb_exp));
            check_output($sformatf("v%0d.busy_a", i), 32'(busy_a), 32'(vecs[i].ba_exp));
            check_output($sformatf("v%0d.busy_b", i), 32'(busy_b), 32'(vecs[i].bb_exp));
            check_output($sformatf("v%0d.lock_err", i), 32'(lock_err), 32'(vecs[i].err_exp));
            check_output($sformatf("v%0d.busy_vec", i), 32'(busy_vec), 32'(vecs[i].vec_exp));
        end

        // Out-of-range write/lock/read on the DEPTH=12 instance
        apply_stimulus(1'b1, 4'd13, 16'hDEAD, 4'd15, 4'd13, 1'b1, 4'd14);
        check_output("d12.ra_data", 32'(ra_data12), 32'h0);
        check_output("d12.rb_data", 32'(rb_data12), 32'h0);
        check_output("d12.busy_a", 32'(busy_a12), 32'h0);
        check_output("d12.busy_b", 32'(busy_b12), 32'h0);
        check_output("d12.lock_err", 32'(lock_err12), 32'h0);
        check_output("d12.busy_vec", 32'(busy_vec12), 32'h200);
        check_output("d16.rb_data13", 32'(rb_data), 32'hDEAD);
        check_output("d16.busy_vec14", 32'(busy_vec), 32'h4200);

        apply_stimulus(1'b0, 4'd0, 16'h0000, 4'd11, 4'd9, 1'b0, 4'd0);
        check_output("d12.ra_data11", 32'(ra_data12), 32'h0);
        check_output("d12.rb_data9", 32'(rb_data12), 32'h5A5A);
        check_output("d12.busy_b9", 32'(busy_b12), 32'h1);
        check_output("d12.busy_vec2", 32'(busy_vec12), 32'h200);

        // Mid-operation reset between edges; the pending write must be lost
        @(negedge clk);
        w        = 1'b1;
        wsel     = 4'd1;
        wdata    = 16'h7777;
        lock     = 1'b1;
        lock_sel = 4'd2;
        #2 rst = 1'b0;
        #1;
        check_output("mid.rb_data", 32'(rb_data), 32'h0);
        check_output("mid.busy_b", 32'(busy_b), 32'h0);
        check_output("mid.busy_vec", 32'(busy_vec), 32'h0);
        check_output("mid.rb_data12", 32'(rb_data12), 32'h0);
        check_output("mid.busy_vec12", 32'(busy_vec12), 32'h0);
        @(posedge clk);
        #1;
        check_output("mid.hold_vec", 32'(busy_vec), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        w        = 1'b0;
        lock     = 1'b0;
        ra_sel   = 4'd0;
        rb_sel   = 4'd1;
        @(posedge clk);
        #1;
        check_output("post.ra_data0", 32'(ra_data), 32'h1);
        check_output("post.rb_data1", 32'(rb_data), 32'h1);
        check_output("post.busy_vec", 32'(busy_vec), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
